// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit of the EX stage.
// Owns the HI/LO registers. MULT/MULTU/DIV/DIVU hold busy for a fixed number
// of cycles and then update HI/LO together with a one-cycle done pulse.
// MTHI/MTLO write HI/LO directly when the unit is idle.
// The arithmetic result is computed combinationally at the accept edge and
// parked in a pending register, so hi/lo never show intermediate values.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {IDLE, RUN} state_t;

  md_op_t op;
  logic   is_mul;
  logic   is_div;
  logic   is_signed;

  assign op        = md_op_t'(md_op);
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  // Arithmetic datapath
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

  // Product and sign-magnitude quotient/remainder for the op on the inputs.
  // Dividing magnitudes keeps MIN/-1 well defined: |MIN| = 2^(W-1) fits
  // unsigned, and the sign fix-up wraps the quotient back to MIN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; that is what keeps the block free of inferred latches.
    a_neg = is_signed & rs_val[WIDTH-1];
    b_neg = is_signed & rt_val[WIDTH-1];
    a_ext = {{WIDTH{a_neg}}, rs_val};
    b_ext = {{WIDTH{b_neg}}, rt_val};
    prod  = a_ext * b_ext;
    a_mag = a_neg ? -rs_val : rs_val;
    b_mag = b_neg ? -rt_val : rt_val;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
  end

  // Control and result state
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_wr;

  // IDLE/RUN sequencer: accept, count down, then commit HI/LO with done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
              res_hi <= is_mul ? prod[2*WIDTH-1:WIDTH] : rem;
              res_lo <= is_mul ? prod[WIDTH-1:0] : quot;
              // Division by zero runs full latency but leaves HI/LO alone.
              res_wr <= is_mul || (rt_val != '0);
            end else if (op == OP_MTHI) begin
              hi <= rs_val;
            end else if (op == OP_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        RUN: begin
          // start is deliberately not looked at here: requests while busy drop.
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (res_wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// The stimulus process keeps an architectural HI/LO model computed with plain
// 64-bit arithmetic and pushes the expected end-of-op state; a monitor on the
// falling edge pops on every done pulse, checks latency and hold behaviour.
module tb_md_unit;

  localparam int W    = 32;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;
  localparam logic [2:0] RSVD  = 3'd7;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [2:0]   md_op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  md_unit #(.WIDTH(W), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cycles;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] m_hi     = '0;
  logic [W-1:0] m_lo     = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: hold checks during busy, scoreboard compare on each done pulse.
  int           busy_cnt  = 0;
  logic         prev_busy = 1'b0;
  logic [W-1:0] prev_hi   = '0;
  logic [W-1:0] prev_lo   = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy && prev_busy) begin
        check("hold_hi", 64'(hi), 64'(prev_hi));
        check("hold_lo", 64'(lo), 64'(prev_lo));
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_hi"},      64'(hi),       64'(e.hi));
          check({e.name, "_lo"},      64'(lo),       64'(e.lo));
          check({e.name, "_latency"}, 64'(busy_cnt), 64'(e.cycles));
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
      prev_hi   = hi;
      prev_lo   = lo;
    end
  end

  // Stimulus tasks run in the phase just after a rising edge.
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Issue a request the model treats as ignored (unit known busy).
  task automatic poke(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = NONE;
  endtask

  // Issue a request with the unit idle and update the reference model.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint           sp, sq, sr;
    logic [2*W-1:0]   up;
    exp_t             e;
    poke(op, a, b);
    case (op)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      DIV: begin
        if (b != 0) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end
      end
      DIVU: begin
        if (b != 0) begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      default: ;
    endcase
    if (op >= MULT && op <= DIVU) begin
      e.name   = (op == MULT) ? "mult" : (op == MULTU) ? "multu" : (op == DIV) ? "div" : "divu";
      e.hi     = m_hi;
      e.lo     = m_lo;
      e.cycles = (op <= MULTU) ? MULN : DIVN;
      sb_q.push_back(e);
      check("accept_busy", 64'(busy), 64'(1));
    end else begin
      check("nobusy", 64'(busy), 64'(0));
      check("nodone", 64'(done), 64'(0));
      check("direct_hi", 64'(hi), 64'(m_hi));
      check("direct_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] old_hi;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    reset_n = 1'b0; start = 1'b0; md_op = NONE; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset_hi",   64'(hi),   64'(0));
    check("reset_lo",   64'(lo),   64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));

    // Reset mid-MULT aborts the op with no later write.
    do_op(MTHI, 32'h1234, 32'h0);
    do_op(MTLO, 32'h5678, 32'h0);
    do_op(MULT, 32'd7, 32'd9);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("abort_hi",   64'(hi),   64'(0));
    check("abort_lo",   64'(lo),   64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (MULN + 3) begin
      @(posedge clk); #1;
    end
    check("post_abort_hi",   64'(hi),   64'(0));
    check("post_abort_lo",   64'(lo),   64'(0));
    check("post_abort_busy", 64'(busy), 64'(0));

    // Directed arithmetic cases.
    do_op(MULT,  32'hFFFF_FFFE, 32'd3);          wait_idle();
    check("mult_neg2x3_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("mult_neg2x3_lo", 64'(lo), 64'(32'hFFFF_FFFA));
    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_idle();
    check("multu_max_hi", 64'(hi), 64'(32'hFFFF_FFFE));
    check("multu_max_lo", 64'(lo), 64'(32'h0000_0001));
    do_op(DIV,   32'hFFFF_FFF9, 32'd2);          wait_idle();
    check("div_m7_2_lo", 64'(lo), 64'(32'hFFFF_FFFD));
    check("div_m7_2_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    do_op(DIVU,  32'hFFFF_FFF9, 32'd2);          wait_idle();
    check("divu_lo", 64'(lo), 64'(32'h7FFF_FFFC));
    check("divu_hi", 64'(hi), 64'(32'h0000_0001));
    do_op(MTHI, 32'h11, 32'h0);
    do_op(MTLO, 32'h22, 32'h0);
    do_op(DIV,  32'h1234_5678, 32'h0);           wait_idle();
    check("div0_hi", 64'(hi), 64'(32'h11));
    check("div0_lo", 64'(lo), 64'(32'h22));
    do_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF);   wait_idle();
    check("div_ovf_lo", 64'(lo), 64'(32'h8000_0000));
    check("div_ovf_hi", 64'(hi), 64'(32'h0));

    // MTHI and another MD op while busy are both ignored.
    old_hi = hi;
    do_op(MULT, 32'd1000, 32'd3000);
    poke(MTHI, 32'hABCD, 32'h0);
    check("mthi_busy_ignored", 64'(hi), 64'(old_hi));
    poke(DIVU, 32'd100, 32'd7);
    wait_idle();
    do_op(MTHI, 32'hABCD, 32'h0);
    check("mthi_idle_hi", 64'(hi), 64'(32'hABCD));

    // Back-to-back MULT in the first idle cycle.
    do_op(MULT, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_idle();
    do_op(MULT, 32'h8000_0000, 32'h8000_0000);
    wait_idle();

    // Ops 0 and 7 do nothing.
    do_op(NONE, 32'h5555_5555, 32'h1);
    do_op(RSVD, 32'h6666_6666, 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = 32'($urandom_range(1, 17));
        default: rb = $urandom;
      endcase
      wait_idle();
      do_op(rop, ra, rb);
      if (rop >= MULT && rop <= DIVU && $urandom_range(0, 3) == 0)
        poke(3'($urandom_range(1, 6)), $urandom, $urandom);
    end

    wait_idle();
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
